// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for ram_ctrl: sequencer states, weight RAM depth,
// write-arbiter grant encoding and the weight-burst start check.
package ram_ctrl_pkg;

  localparam int WEI_DEPTH = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } wseq_state_t;

  localparam logic GNT_LOADER = 1'b0;
  localparam logic GNT_CONV   = 1'b1;

  // A burst must be non-empty, fit in the RAM, and start inside it.
  function automatic logic start_ok(input int base, input int count, input int depth);
    return (count >= 1) && (count <= depth) && (base < depth);
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// Bus bundle between ram_ctrl and its environment: write requesters, RAM pixel
// write port, weight burst control/read port and the contention statistic.
interface ram_ctrl_if #(
  parameter int SIZE_1           = 16,
  parameter int SIZE_address_pix = 16,
  parameter int SIZE_address_wei = 4
);

  logic                        l_valid;
  logic                        l_ready;
  logic [SIZE_address_pix-1:0] l_addr;
  logic [SIZE_1-1:0]           l_data;

  logic                        c_valid;
  logic                        c_ready;
  logic [SIZE_address_pix-1:0] c_addr;
  logic [SIZE_1-1:0]           c_data;

  logic                        we_p;
  logic [SIZE_address_pix-1:0] write_addressp;
  logic [SIZE_1-1:0]           dp;

  logic                        w_start;
  logic [SIZE_address_wei-1:0] w_base;
  logic [3:0]                  w_count;

  logic                        re_w;
  logic [SIZE_address_wei-1:0] read_addressw;
  logic                        w_busy;
  logic                        w_valid;
  logic [3:0]                  w_index;
  logic                        w_err;

  logic [15:0]                 conflict_cnt;

  modport master (
    output l_valid, l_addr, l_data,
    output c_valid, c_addr, c_data,
    output w_start, w_base, w_count,
    input  l_ready, c_ready,
    input  we_p, write_addressp, dp,
    input  re_w, read_addressw, w_busy, w_valid, w_index, w_err,
    input  conflict_cnt
  );

  modport slave (
    input  l_valid, l_addr, l_data,
    input  c_valid, c_addr, c_data,
    input  w_start, w_base, w_count,
    output l_ready, c_ready,
    output we_p, write_addressp, dp,
    output re_w, read_addressw, w_busy, w_valid, w_index, w_err,
    output conflict_cnt
  );

endinterface

// File: rtl/wei_read_seq.sv
// Weight RAM burst sequencer: IDLE -> READ (count cycles, wrapping address) ->
// DRAIN (one cycle for the last RAM read to land) -> IDLE.
module wei_read_seq
  import ram_ctrl_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = WEI_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [3:0]    i_count,
  output logic          o_re,
  output logic [AW-1:0] o_addr,
  output logic          o_busy,
  output logic          o_valid,
  output logic [3:0]    o_index,
  output logic          o_err
);

  wseq_state_t   r_state;
  wseq_state_t   w_state_next;

  logic [AW-1:0] r_addr;
  logic [3:0]    r_idx;
  logic [3:0]    r_cnt;
  logic          r_valid;
  logic [3:0]    r_index;
  logic          r_err;

  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == ST_IDLE) && i_start &&
                    start_ok(int'(i_base), int'(i_count), DEPTH);
  assign w_last   = (r_idx == (r_cnt - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_READ;
      ST_READ:  if (w_last)   w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Starts seen while busy are neither accepted nor flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_READ);
      r_index <= r_idx;
      r_err   <= (r_state == ST_IDLE) && i_start && !w_accept;
      if (w_accept) begin
        r_addr <= i_base;
        r_idx  <= '0;
        r_cnt  <= i_count;
      end else if ((r_state == ST_READ) && !w_last) begin
        r_idx  <= r_idx + 4'd1;
        r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
      end
    end
  end

  assign o_re    = (r_state == ST_READ);
  assign o_busy  = (r_state != ST_IDLE);
  assign o_addr  = r_addr;
  assign o_valid = r_valid;
  assign o_index = r_index;
  assign o_err   = r_err;

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: round-robin pixel write arbiter (loader vs conv) plus an
// independent weight burst sequencer. Define RAM_CTRL_STATS_EN for conflict_cnt.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int SIZE_1           = 16,
  parameter int SIZE_12          = 16,
  parameter int SIZE_address_pix = 16,
  parameter int SIZE_address_wei = 4,
  parameter int WEI_DEPTH        = ram_ctrl_pkg::WEI_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  ram_ctrl_if.slave bus
);

  logic                        r_last_grant;
  logic                        r_we;
  logic [SIZE_address_pix-1:0] r_waddr;
  logic [SIZE_1-1:0]           r_wdata;

  logic                        w_l_ready;
  logic                        w_c_ready;
  logic                        w_l_xfer;
  logic                        w_c_xfer;

  // On a tie the requester that did not win the last completed transfer goes.
  assign w_l_ready = bus.l_valid && (!bus.c_valid || (r_last_grant == GNT_CONV));
  assign w_c_ready = bus.c_valid && (!bus.l_valid || (r_last_grant == GNT_LOADER));
  assign w_l_xfer  = bus.l_valid && w_l_ready;
  assign w_c_xfer  = bus.c_valid && w_c_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GNT_CONV;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= w_l_xfer || w_c_xfer;
      if (w_l_xfer) begin
        r_last_grant <= GNT_LOADER;
        r_waddr      <= bus.l_addr;
        r_wdata      <= bus.l_data;
      end else if (w_c_xfer) begin
        r_last_grant <= GNT_CONV;
        r_waddr      <= bus.c_addr;
        r_wdata      <= bus.c_data;
      end
    end
  end

  assign bus.l_ready        = w_l_ready;
  assign bus.c_ready        = w_c_ready;
  assign bus.we_p           = r_we;
  assign bus.write_addressp = r_waddr;
  assign bus.dp             = r_wdata;

`ifdef RAM_CTRL_STATS_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_conflict_cnt <= '0;
    else if (bus.l_valid && bus.c_valid && (r_conflict_cnt != 16'hFFFF))
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign bus.conflict_cnt = r_conflict_cnt;
`else
  assign bus.conflict_cnt = 16'd0;
`endif

  wei_read_seq #(
    .AW    (SIZE_address_wei),
    .DEPTH (WEI_DEPTH)
  ) u_wei_read_seq (
    .clk     (clk),
    .rst     (rst),
    .i_start (bus.w_start),
    .i_base  (bus.w_base),
    .i_count (bus.w_count),
    .o_re    (bus.re_w),
    .o_addr  (bus.read_addressw),
    .o_busy  (bus.w_busy),
    .o_valid (bus.w_valid),
    .o_index (bus.w_index),
    .o_err   (bus.w_err)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl: arbitration, registered write
// port, weight bursts with wrap, rejected starts and mid-burst reset.
module tb_ram_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ram_ctrl_if #(
    .SIZE_1           (16),
    .SIZE_address_pix (16),
    .SIZE_address_wei (4)
  ) bus ();

  ram_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_CTRL_STATS_EN
  localparam logic [15:0] EXP_CONFLICT = 16'd4;
`else
  localparam logic [15:0] EXP_CONFLICT = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_addr [4];
  logic        exp_l [4];
  logic [15:0] exp_wa [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.l_valid = 1'b0; bus.l_addr = '0; bus.l_data = '0;
    bus.c_valid = 1'b0; bus.c_addr = '0; bus.c_data = '0;
    bus.w_start = 1'b0; bus.w_base = '0; bus.w_count = '0;

    // Reset state
    tick(); tick();
    $display("[TB] reset state");
    chk("rst_we_p", 32'(bus.we_p), 32'd0);
    chk("rst_waddr", 32'(bus.write_addressp), 32'd0);
    chk("rst_dp", 32'(bus.dp), 32'd0);
    chk("rst_re_w", 32'(bus.re_w), 32'd0);
    chk("rst_raddr", 32'(bus.read_addressw), 32'd0);
    chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
    chk("rst_w_index", 32'(bus.w_index), 32'd0);
    chk("rst_w_busy", 32'(bus.w_busy), 32'd0);
    chk("rst_w_err", 32'(bus.w_err), 32'd0);
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    rst = 1'b0;

    // Loader-only write
    bus.l_valid = 1'b1; bus.l_addr = 16'd5; bus.l_data = 16'h00AB;
    #1;
    $display("[TB] loader write addr=5 data=0x0AB");
    chk("lonly_l_ready", 32'(bus.l_ready), 32'd1);
    chk("lonly_c_ready", 32'(bus.c_ready), 32'd0);
    tick();
    bus.l_valid = 1'b0;
    chk("lonly_we_p", 32'(bus.we_p), 32'd1);
    chk("lonly_waddr", 32'(bus.write_addressp), 32'd5);
    chk("lonly_dp", 32'(bus.dp), 32'h00AB);
    tick();
    chk("idle_we_p", 32'(bus.we_p), 32'd0);

    // Contention right after reset: L,C,L,C
    rst = 1'b1; tick(); rst = 1'b0;
    exp_l  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_wa = '{16'd1, 16'd2, 16'd1, 16'd2};
    bus.l_valid = 1'b1; bus.l_addr = 16'd1; bus.l_data = 16'h0111;
    bus.c_valid = 1'b1; bus.c_addr = 16'd2; bus.c_data = 16'h0222;
    for (int k = 0; k < 4; k++) begin
      #1;
      $display("[TB] contention cycle %0d expect %s", k, exp_l[k] ? "L" : "C");
      chk("rr_l_ready", 32'(bus.l_ready), 32'(exp_l[k]));
      chk("rr_c_ready", 32'(bus.c_ready), 32'(!exp_l[k]));
      tick();
      chk("rr_we_p", 32'(bus.we_p), 32'd1);
      chk("rr_waddr", 32'(bus.write_addressp), 32'(exp_wa[k]));
      chk("rr_dp", 32'(bus.dp), exp_l[k] ? 32'h0111 : 32'h0222);
    end
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(EXP_CONFLICT));
    bus.l_valid = 1'b0;
    // Conv alone is granted even though it won last
    #1;
    $display("[TB] conv-only write addr=2");
    chk("conly_c_ready", 32'(bus.c_ready), 32'd1);
    chk("conly_l_ready", 32'(bus.l_ready), 32'd0);
    tick();
    bus.c_valid = 1'b0;
    chk("conly_we_p", 32'(bus.we_p), 32'd1);
    tick();
    chk("conly_idle_we_p", 32'(bus.we_p), 32'd0);
    chk("conflict_hold", 32'(bus.conflict_cnt), 32'(EXP_CONFLICT));

    // Weight burst base=12 count=4 with wrap
    exp_addr = '{4'd12, 4'd13, 4'd0, 4'd1};
    bus.w_start = 1'b1; bus.w_base = 4'd12; bus.w_count = 4'd4;
    tick();
    bus.w_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      $display("[TB] burst read cycle %0d", i);
      chk("burst_re_w", 32'(bus.re_w), 32'd1);
      chk("burst_raddr", 32'(bus.read_addressw), 32'(exp_addr[i]));
      chk("burst_busy", 32'(bus.w_busy), 32'd1);
      chk("burst_w_valid", 32'(bus.w_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("burst_w_index", 32'(bus.w_index), 32'(i - 1));
      tick();
    end
    $display("[TB] burst drain, start while busy");
    chk("drain_re_w", 32'(bus.re_w), 32'd0);
    chk("drain_busy", 32'(bus.w_busy), 32'd1);
    chk("drain_w_valid", 32'(bus.w_valid), 32'd1);
    chk("drain_w_index", 32'(bus.w_index), 32'd3);
    bus.w_start = 1'b1; bus.w_base = 4'd0; bus.w_count = 4'd1;
    tick();
    bus.w_start = 1'b0;
    chk("post_busy", 32'(bus.w_busy), 32'd0);
    chk("post_re_w", 32'(bus.re_w), 32'd0);
    chk("post_w_valid", 32'(bus.w_valid), 32'd0);
    chk("busy_start_no_err", 32'(bus.w_err), 32'd0);
    tick();
    chk("busy_start_ignored", 32'(bus.re_w), 32'd0);

    // Rejected starts
    bus.w_start = 1'b1; bus.w_base = 4'd0; bus.w_count = 4'd0;
    tick();
    bus.w_start = 1'b0;
    $display("[TB] reject count=0");
    chk("rej0_w_err", 32'(bus.w_err), 32'd1);
    chk("rej0_re_w", 32'(bus.re_w), 32'd0);
    chk("rej0_busy", 32'(bus.w_busy), 32'd0);
    tick();
    chk("rej0_err_clear", 32'(bus.w_err), 32'd0);
    bus.w_start = 1'b1; bus.w_base = 4'd14; bus.w_count = 4'd1;
    tick();
    bus.w_start = 1'b0;
    $display("[TB] reject base=14");
    chk("rejb_w_err", 32'(bus.w_err), 32'd1);
    chk("rejb_re_w", 32'(bus.re_w), 32'd0);
    tick();
    chk("rejb_err_clear", 32'(bus.w_err), 32'd0);
    bus.w_start = 1'b1; bus.w_base = 4'd0; bus.w_count = 4'd15;
    tick();
    bus.w_start = 1'b0;
    $display("[TB] reject count=15");
    chk("rejc_w_err", 32'(bus.w_err), 32'd1);
    chk("rejc_re_w", 32'(bus.re_w), 32'd0);
    tick();

    // Reset on the 2nd READ cycle of a count=9 burst, with a write in flight
    bus.w_start = 1'b1; bus.w_base = 4'd3; bus.w_count = 4'd9;
    tick();
    bus.w_start = 1'b0;
    $display("[TB] burst count=9 then reset");
    chk("b9_raddr0", 32'(bus.read_addressw), 32'd3);
    tick();
    chk("b9_raddr1", 32'(bus.read_addressw), 32'd4);
    chk("b9_w_valid", 32'(bus.w_valid), 32'd1);
    rst = 1'b1;
    bus.l_valid = 1'b1; bus.l_addr = 16'd9; bus.l_data = 16'h0999;
    tick();
    rst = 1'b0;
    bus.l_valid = 1'b0;
    chk("mrst_re_w", 32'(bus.re_w), 32'd0);
    chk("mrst_w_valid", 32'(bus.w_valid), 32'd0);
    chk("mrst_busy", 32'(bus.w_busy), 32'd0);
    chk("mrst_we_p", 32'(bus.we_p), 32'd0);
    bus.w_start = 1'b1; bus.w_base = 4'd13; bus.w_count = 4'd1;
    tick();
    bus.w_start = 1'b0;
    $display("[TB] start right after reset");
    chk("after_rst_re_w", 32'(bus.re_w), 32'd1);
    chk("after_rst_raddr", 32'(bus.read_addressw), 32'd13);
    chk("after_rst_w_err", 32'(bus.w_err), 32'd0);
    tick();
    chk("after_rst_drain_valid", 32'(bus.w_valid), 32'd1);
    chk("after_rst_drain_index", 32'(bus.w_index), 32'd0);
    tick();
    chk("after_rst_idle", 32'(bus.w_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameters (name, default, meaning); each SHALL exist with the stated default:
- SIZE_1, 16, pixel data width.
- SIZE_12, 16, weight data width.
- SIZE_address_pix, 16, pixel address width.
- SIZE_address_wei, 4, weight address width.
- WEI_DEPTH, 14, number of weight RAM entries.
REQ-002 Ports (name, direction, width, meaning); each SHALL exist as stated:
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- l_valid/l_ready, in/out, 1/1, loader pixel-write handshake.
- l_addr/l_data, in/in, SIZE_address_pix/SIZE_1, loader write address and data.
- c_valid/c_ready, in/out, 1/1, conv write-back handshake.
- c_addr/c_data, in/in, SIZE_address_pix/SIZE_1, conv write address and data.
- we_p/write_addressp/dp, out, 1/SIZE_address_pix/SIZE_1, RAM pixel write port.
- w_start, in, 1, start weight burst.
- w_base, in, SIZE_address_wei, first weight address.
- w_count, in, 4, burst length.
- re_w/read_addressw, out, 1/SIZE_address_wei, RAM weight read port.
- w_busy, out, 1, burst in progress.
- w_valid, out, 1, RAM qw valid this cycle.
- w_index, out, 4, burst position of the qw word.
- w_err, out, 1, one-cycle pulse on a rejected start.
- conflict_cnt, out, 16, contention statistic.

Function
REQ-003 Write arbitration: a transfer occurs on a requester when valid && ready; at most one ready per cycle.
REQ-004 One requester valid: that requester's ready is high in the same cycle (combinational).
REQ-005 Both valid: round-robin; the requester not granted last wins; last_grant updates only on a completed transfer.
REQ-006 A transfer in cycle N drives we_p=1 plus the registered address and data in cycle N+1; no transfer in N gives we_p=0 in N+1.
REQ-007 Weight sequencer FSM states: IDLE, READ, DRAIN.
REQ-008 IDLE->READ on w_start with 1<=w_count<=WEI_DEPTH and w_base<WEI_DEPTH; base and count are latched at that edge.
REQ-009 Any other w_start in IDLE (count 0, count>WEI_DEPTH, or base>=WEI_DEPTH) is rejected: w_err pulses 1 cycle and the FSM stays in IDLE.
REQ-010 READ: re_w=1 for exactly count cycles; read_addressw=(base+i) mod WEI_DEPTH, i=0..count-1.
REQ-011 The last READ cycle transitions to DRAIN; DRAIN lasts 1 cycle, then the FSM returns to IDLE.
REQ-012 w_valid is re_w delayed 1 cycle (RAM read latency); w_index is i delayed 1 cycle.
REQ-013 w_busy=1 in READ and DRAIN; w_start while busy is ignored with no w_err; a new start is accepted on the cycle after DRAIN.
REQ-014 Write arbitration and the weight sequencer are independent and operate concurrently.

Reset
REQ-015 rst (synchronous) SHALL force: we_p=0, write_addressp=0, dp=0, re_w=0, read_addressw=0, w_valid=0, w_index=0, w_busy=0, w_err=0, FSM=IDLE, last_grant=conv (loader wins first tie), conflict_cnt=0.
REQ-016 Reset mid-burst aborts the burst: no w_valid in the cycle after reset.
REQ-017 Reset mid-burst drops any pending registered write.

Configuration
REQ-018 Macro RAM_CTRL_STATS_EN defined: conflict_cnt increments on each cycle where l_valid && c_valid, saturating at 16'hFFFF.
REQ-019 Macro RAM_CTRL_STATS_EN undefined: conflict_cnt is constant 0 and no counter logic is synthesised.

Structure
REQ-020 Shared package ram_ctrl_pkg SHALL hold the FSM state typedef, the WEI_DEPTH constant and the grant encoding constants.
REQ-021 The weight sequencer SHALL be sub-module wei_read_seq; the arbiter SHALL be inline in ram_ctrl.

Verification
REQ-022 Loader only, l_valid=1, addr 5, data 0x0AB -> l_ready same cycle; next cycle we_p=1, write_addressp=5, dp=0x0AB.
REQ-023 Both valid for 4 cycles after reset -> grants L,C,L,C; conflict_cnt=4 with the macro, 0 without it.
REQ-024 w_start, base=12, count=4 -> read_addressw 12,13,0,1; w_valid on the next 4 cycles with w_index 0..3; w_busy for 5 cycles.
REQ-025 w_start with count=0, then w_start with base=14 -> w_err pulses each time; re_w stays 0.
REQ-026 rst asserted on the 2nd READ cycle of a count=9 burst -> next cycle re_w=0, w_valid=0, w_busy=0; a w_start right after reset is accepted.
